serial_bits8: RTL and testbench

SERIAL_BITS8 -- requirements
Module: serial_bits8

---
 rtl/serial_bits8.sv | 93 +++++++++
 tb/tb_serial_bits8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_bits8.sv
// Serial-to-byte deserializer: comma-based byte alignment with a
// SEARCH/ALIGN/ACTIVE lock sequence and registered byte outputs.
module serial_bits8 #(
   parameter logic [7:0] COMMA      = 8'hBC,
   parameter int         SYNC_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] Data_out,
   output logic       valid_out,
   output logic       byte_strobe,
   output logic       active
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [2:0] SYNC_N = 3'(SYNC_COUNT);

   state_t     state;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic [2:0] bc_cnt;
   logic [7:0] next_byte;
   logic       is_comma;
   logic       boundary;

   assign next_byte = {sr[6:0], data_in};
   assign is_comma  = (next_byte == COMMA);
   assign boundary  = (bit_cnt == 3'd7);

   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state       <= SEARCH;
         sr          <= 8'd0;
         bit_cnt     <= 3'd0;
         bc_cnt      <= 3'd0;
         Data_out    <= 8'd0;
         valid_out   <= 1'b0;
         byte_strobe <= 1'b0;
         active      <= 1'b0;
      end else begin
         sr          <= next_byte;
         bit_cnt     <= bit_cnt + 3'd1;
         byte_strobe <= 1'b0;
         case (state)
            SEARCH: begin
               if (is_comma) begin
                  // Byte framing is pinned to this edge; the next boundary is 8 edges out.
                  bit_cnt <= 3'd0;
                  bc_cnt  <= 3'd1;
                  if (SYNC_N == 3'd1) begin
                     state  <= ACTIVE;
                     active <= 1'b1;
                  end else begin
                     state <= ALIGN;
                  end
               end else begin
                  bc_cnt <= 3'd0;
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (is_comma) begin
                     bc_cnt <= bc_cnt + 3'd1;
                     if (bc_cnt + 3'd1 == SYNC_N) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     state  <= SEARCH;
                     bc_cnt <= 3'd0;
                  end
               end
            end
            ACTIVE: begin
               // Lock is held until reset; commas become idle bytes.
               if (boundary) begin
                  Data_out    <= next_byte;
                  byte_strobe <= 1'b1;
                  valid_out   <= !is_comma;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_bits8.sv
// Randomized and directed bench for serial_bits8 (default and SYNC_COUNT=1),
// checked cycle by cycle against a bit-stream scanning reference.
module tb_serial_bits8;
   localparam logic [7:0] COMMA = 8'hBC;
   localparam int MAXN = 1024;

   logic            clk_32f = 1'b0;
   logic            reset   = 1'b0;
   logic            data_in = 1'b0;
   logic [1:0][7:0] data_o;
   logic [1:0]      vld_o, stb_o, act_o;

   int n_cmp = 0;
   int n_err = 0;

   bit          stim[$];
   logic [10:0] e_pk [2][MAXN];
   logic [31:0] word;

   always #5 clk_32f = ~clk_32f;

   serial_bits8 #(.COMMA(COMMA), .SYNC_COUNT(4)) u_dut (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .Data_out(data_o[0]), .valid_out(vld_o[0]),
      .byte_strobe(stb_o[0]), .active(act_o[0])
   );

   serial_bits8 #(.COMMA(COMMA), .SYNC_COUNT(1)) u_dut1 (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
      .Data_out(data_o[1]), .valid_out(vld_o[1]),
      .byte_strobe(stb_o[1]), .active(act_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // The 8 bits ending at stream index i; bits before the segment are 0 (sr cleared by reset).
   function automatic logic [7:0] win(input int i);
      logic [7:0] w;
      int idx;
      w = 8'd0;
      for (int k = 0; k < 8; k++) begin
         idx = i - 7 + k;
         w = {w[6:0], (idx >= 0) ? stim[idx] : 1'b0};
      end
      return w;
   endfunction

   // Find the lock point by scanning the stream for SC comma bytes 8 bits apart,
   // restarting the scan one bit after a failed run; then emit a byte every 8 bits.
   task automatic build_model(input int d, input int sc);
      int n, i, j, k, act_at;
      logic [7:0] dq;
      bit vq, on, st;
      n = stim.size();
      i = 0;
      act_at = -1;
      while (i < n) begin
         if (win(i) == COMMA) begin
            j = i;
            k = 1;
            while (k < sc && j + 8 < n && win(j + 8) == COMMA) begin
               j += 8;
               k++;
            end
            if (k == sc) begin
               act_at = j;
               break;
            end
            i = j + 9;
         end else begin
            i++;
         end
      end
      dq = 8'd0;
      vq = 1'b0;
      for (int t = 0; t < n; t++) begin
         on = (act_at >= 0) && (t >= act_at);
         st = (act_at >= 0) && (t > act_at) && ((t - act_at) % 8 == 0);
         if (st) begin
            dq = win(t);
            vq = (dq != COMMA);
         end
         e_pk[d][t] = {on, st, vq, dq};
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int k = 7; k >= 0; k--) stim.push_back(b[k]);
   endtask

   task automatic push_rand_bits(input int n);
      for (int k = 0; k < n; k++) stim.push_back(1'($urandom_range(0, 1)));
   endtask

   task automatic run_seg(input string name);
      build_model(0, 4);
      build_model(1, 1);
      for (int t = 0; t < stim.size(); t++) begin
         @(negedge clk_32f);
         data_in = stim[t];
         @(posedge clk_32f);
         #1;
         for (int d = 0; d < 2; d++)
            chk($sformatf("%s d%0d t%0d", name, d, t),
                32'({act_o[d], stb_o[d], vld_o[d], data_o[d]}), 32'(e_pk[d][t]));
         if (stb_o[0] && vld_o[0]) word = {word[23:0], data_o[0]};
      end
      stim.delete();
   endtask

   // Async reset asserted between edges; outputs must clear before any clock edge.
   task automatic pulse_reset(input string name);
      @(negedge clk_32f);
      #2;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("%s rst d%0d", name, d),
             32'({act_o[d], stb_o[d], vld_o[d], data_o[d]}), 32'd0);
      @(posedge clk_32f);
      @(negedge clk_32f);
      reset = 1'b1;
   endtask

   initial begin
      word = 32'd0;
      pulse_reset("init");

      // Lock after 4 commas, then two data bytes 8 cycles apart
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'h12); push_byte(8'h34); push_byte(8'h00);
      run_seg("lock");

      // ALIGN aborted by a non-comma, then a full comma run
      pulse_reset("abort");
      for (int k = 0; k < 3; k++) push_byte(COMMA);
      push_byte(8'h55);
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'hA0); push_byte(8'h00);
      run_seg("abort");

      // Stream shifted by 3 random bits
      pulse_reset("skew");
      push_rand_bits(3);
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'hFF); push_byte(8'h00);
      run_seg("skew");

      // Idle commas inside ACTIVE
      pulse_reset("idle");
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(COMMA); push_byte(8'h01); push_byte(COMMA);
      run_seg("idle");

      // Reset mid-byte while ACTIVE, then relock from scratch
      pulse_reset("mid");
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'h12);
      for (int k = 0; k < 4; k++) stim.push_back(1'b1);
      run_seg("mid_a");
      pulse_reset("mid");
      for (int k = 0; k < 3; k++) push_byte(COMMA);
      push_byte(8'h66);
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'h77); push_byte(COMMA);
      run_seg("mid_b");

      // Bytes packed MSB-first into a word as a downstream stage would
      pulse_reset("chain");
      word = 32'd0;
      for (int k = 0; k < 4; k++) push_byte(COMMA);
      push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
      push_byte(COMMA);
      run_seg("chain");
      chk("chain word", word, 32'hDEADBEEF);

      // Random streams: random skew, comma-heavy preamble, mixed payload
      for (int r = 0; r < 8; r++) begin
         pulse_reset("rand");
         push_rand_bits($urandom_range(0, 7));
         for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 99) < ((k < 6) ? 80 : 30)) push_byte(COMMA);
            else push_byte(8'($urandom_range(0, 255)));
         end
         run_seg($sformatf("rand%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
